enigma_stream_sequencer: RTL and testbench
==========================================

ENIGMA_STREAM_SEQUENCER -- requirements
Module: enigma_stream_sequencer

Interface
REQ-001 SHALL have parameter ENGINE_LATENCY, default 2: WAIT-state cycles between the rotate pulse and output capture.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two ≥2: output buffer entries.
REQ-003 SHALL have parameter PASS_NONALPHA, default 1: 1 = forward non-letter bytes unchanged, 0 = drop them.
REQ-004 i_clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_rx_data  input  8  host ASCII byte.
REQ-007 i_rx_valid  input  1  host byte present.
REQ-008 o_rx_ready  output  1  byte accepted on cycles where i_rx_valid && o_rx_ready.
REQ-009 o_inputData  output  8  byte presented to the cipher engine.
REQ-010 o_rotate  output  1  one-cycle rotor-step strobe to the engine.
REQ-011 i_outputData  input  8  enciphered byte from the engine.
REQ-012 i_valid  input  1  engine's registered letter-valid flag.
REQ-013 i_update_settings  input  1  engine settings reload in progress.
REQ-014 o_tx_data  output  8  head of output FIFO.
REQ-015 o_tx_valid  output  1  FIFO non-empty.
REQ-016 i_tx_ready  input  1  sink pops on o_tx_valid && i_tx_ready.
REQ-017 o_busy  output  1  high whenever state ≠ IDLE.
REQ-018 o_char_count  output  16  enciphered letters pushed, saturating.
REQ-019 o_drop_count  output  16  bytes discarded, saturating.

Function
REQ-020 SHALL implement the states IDLE, STEP, WAIT and CAPTURE.
REQ-021 o_rx_ready SHALL equal (state==IDLE) && FIFO count < FIFO_DEPTH && !i_update_settings.
REQ-022 A letter is 0x41–0x5A or 0x61–0x7A; on an accepted letter, SHALL latch it into o_inputData and go to STEP.
REQ-023 On an accepted non-letter: PASS_NONALPHA=1 SHALL push the byte on the same edge; PASS_NONALPHA=0 SHALL increment o_drop_count; either way SHALL stay IDLE, no o_rotate.
REQ-024 STEP SHALL assert o_rotate for exactly one cycle, then go to WAIT with a counter loaded with ENGINE_LATENCY.
REQ-025 WAIT SHALL decrement the counter each cycle and go to CAPTURE on the cycle after it reaches 1.
REQ-026 CAPTURE SHALL sample i_valid and i_outputData: if valid, push i_outputData and increment o_char_count, else increment o_drop_count; then go to IDLE.
REQ-027 o_inputData SHALL hold its latched value until the next accepted byte.
REQ-028 Accepted letter to o_tx_valid (empty FIFO) latency SHALL be ENGINE_LATENCY+3 cycles.
REQ-029 i_update_settings high in STEP, WAIT or CAPTURE SHALL abort the character: no push, o_drop_count+1, next state IDLE.
REQ-030 FIFO push only when count < FIFO_DEPTH (guaranteed by REQ-021); a simultaneous push and pop SHALL leave count unchanged; a pop when empty SHALL be ignored.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; o_tx_data SHALL be stable while o_tx_valid && !i_tx_ready.
REQ-032 Counters SHALL saturate at 0xFFFF and not wrap.
REQ-033 At most one character SHALL be in flight; no byte is accepted outside IDLE.

Reset
REQ-034 On reset assertion, without waiting for a clock edge: state=IDLE; o_rotate=0; o_inputData=0x00; FIFO empty (o_tx_valid=0, o_tx_data=0x00); counters=0; o_busy=0.
REQ-035 Reset mid-operation SHALL discard the in-flight character and FIFO contents without counting a drop.
REQ-036 o_rx_ready SHALL be asserted on the first cycle after reset release, subject to REQ-021.

Verification
REQ-037 'A' (0x41) accepted at edge 0, engine returns 0x42 with i_valid=1 -> o_rotate high only in cycle 1; o_tx_valid=1, o_tx_data=0x42 after edge 5; o_char_count=1.
REQ-038 0x20 with PASS_NONALPHA=1 -> o_tx_data=0x20 after edge 1, o_rotate never high; with PASS_NONALPHA=0 -> no push, o_drop_count=1.
REQ-039 i_tx_ready=0, stream 5 letters -> o_rx_ready low after the 4th push; raising i_tx_ready drains 4 bytes in order; 5th accepted next.
REQ-040 Letter with engine i_valid=0 at CAPTURE -> no push, o_drop_count=1, back to IDLE.
REQ-041 i_update_settings pulsed during WAIT -> no push, o_drop_count+1, IDLE next cycle; o_rx_ready held low while it stays high.
REQ-042 Reset asserted in WAIT with 2 bytes queued -> o_rotate=0, o_tx_valid=0 and counters 0 immediately; o_rx_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/enigma_stream_sequencer.sv
// Enigma stream sequencer: accepts host bytes, steps the cipher engine once
// per letter, waits out the engine latency, and queues results in a small FIFO.
module enigma_stream_sequencer #(
    parameter int ENGINE_LATENCY = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int PASS_NONALPHA  = 1
) (
    input  logic        i_clock,
    input  logic        reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_inputData,
    output logic        o_rotate,
    input  logic [7:0]  i_outputData,
    input  logic        i_valid,
    input  logic        i_update_settings,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic [15:0] o_char_count,
    output logic [15:0] o_drop_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(ENGINE_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE, STEP, WAIT, CAPTURE} state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            is_letter;
    logic            accept;
    logic            push;
    logic            pop;
    logic [7:0]      push_data;
    logic            char_inc;
    logic            drop_inc;

    assign is_letter  = ((i_rx_data >= 8'h41) && (i_rx_data <= 8'h5A)) ||
                        ((i_rx_data >= 8'h61) && (i_rx_data <= 8'h7A));
    assign o_rx_ready = (state == IDLE) && (count < (AW+1)'(FIFO_DEPTH)) && !i_update_settings;
    assign accept     = i_rx_valid && o_rx_ready;
    assign o_busy     = (state != IDLE);
    assign o_tx_valid = (count != '0);
    // Gate the head so an empty FIFO always presents 0x00, including in reset.
    assign o_tx_data  = o_tx_valid ? mem[rd_ptr] : 8'h00;
    assign pop        = o_tx_valid && i_tx_ready;

    // Decide what gets pushed and which counter moves this cycle.
    always_comb begin
        push      = 1'b0;
        push_data = i_rx_data;
        char_inc  = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !is_letter) begin
                    if (PASS_NONALPHA != 0) push = 1'b1;
                    else                    drop_inc = 1'b1;
                end
            end
            STEP, WAIT: begin
                if (i_update_settings) drop_inc = 1'b1;
            end
            CAPTURE: begin
                if (i_update_settings) begin
                    drop_inc = 1'b1;
                end else if (i_valid) begin
                    push      = 1'b1;
                    push_data = i_outputData;
                    char_inc  = 1'b1;
                end else begin
                    drop_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Character sequencing FSM; one character in flight at a time.
    always_ff @(posedge i_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            o_rotate    <= 1'b0;
            o_inputData <= 8'h00;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_rotate <= 1'b0;
                    if (accept) begin
                        o_inputData <= i_rx_data;
                        if (is_letter) begin
                            state    <= STEP;
                            o_rotate <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    o_rotate <= 1'b0;
                    if (i_update_settings) begin
                        state <= IDLE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= CW'(ENGINE_LATENCY);
                    end
                end
                WAIT: begin
                    // Counter passes through 1 and then 0, so WAIT spans
                    // ENGINE_LATENCY+1 cycles before the capture.
                    if (i_update_settings)     state <= IDLE;
                    else if (wait_cnt == '0)   state <= CAPTURE;
                    else                       wait_cnt <= wait_cnt - 1'b1;
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    o_rotate <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge i_clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge i_clock or posedge reset) begin
        if (reset) begin
            o_char_count <= 16'h0000;
            o_drop_count <= 16'h0000;
        end else begin
            if (char_inc && (o_char_count != 16'hFFFF)) o_char_count <= o_char_count + 16'h0001;
            if (drop_inc && (o_drop_count != 16'hFFFF)) o_drop_count <= o_drop_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_enigma_stream_sequencer.sv
// Directed bench for enigma_stream_sequencer; a second instance with
// PASS_NONALPHA=0 shares the stimulus to cover the drop path.
module tb_enigma_stream_sequencer;

    logic        i_clock;
    logic        reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  i_outputData;
    logic        i_valid;
    logic        i_update_settings;
    logic        i_tx_ready;

    logic        d1_rx_ready, d1_rotate, d1_tx_valid, d1_busy;
    logic [7:0]  d1_inputData, d1_tx_data;
    logic [15:0] d1_char_count, d1_drop_count;

    logic        d0_rx_ready, d0_rotate, d0_tx_valid, d0_busy;
    logic [7:0]  d0_inputData, d0_tx_data;
    logic [15:0] d0_char_count, d0_drop_count;

    int errors = 0;
    int checks = 0;

    enigma_stream_sequencer #(.ENGINE_LATENCY(2), .FIFO_DEPTH(4), .PASS_NONALPHA(1)) dut (
        .i_clock(i_clock), .reset(reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(d1_rx_ready),
        .o_inputData(d1_inputData), .o_rotate(d1_rotate),
        .i_outputData(i_outputData), .i_valid(i_valid), .i_update_settings(i_update_settings),
        .o_tx_data(d1_tx_data), .o_tx_valid(d1_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(d1_busy), .o_char_count(d1_char_count), .o_drop_count(d1_drop_count)
    );

    enigma_stream_sequencer #(.ENGINE_LATENCY(2), .FIFO_DEPTH(4), .PASS_NONALPHA(0)) dut0 (
        .i_clock(i_clock), .reset(reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(d0_rx_ready),
        .o_inputData(d0_inputData), .o_rotate(d0_rotate),
        .i_outputData(i_outputData), .i_valid(i_valid), .i_update_settings(i_update_settings),
        .o_tx_data(d0_tx_data), .o_tx_valid(d0_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(d0_busy), .o_char_count(d0_char_count), .o_drop_count(d0_drop_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Wait (bounded) for ready, present one letter, then let it run to capture.
    task automatic send_letter(input logic [7:0] b, input logic [7:0] o, input logic v);
        int n = 0;
        while (!d1_rx_ready && n < 20) begin
            tick();
            n++;
        end
        chk("rdy_wait", {31'd0, d1_rx_ready}, 32'd1);
        i_rx_data    = b;
        i_outputData = o;
        i_valid      = v;
        i_rx_valid   = 1'b1;
        tick();
        i_rx_valid   = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        reset             = 1'b1;
        i_rx_data         = 8'h00;
        i_rx_valid        = 1'b0;
        i_outputData      = 8'h00;
        i_valid           = 1'b0;
        i_update_settings = 1'b0;
        i_tx_ready        = 1'b0;
        #2;
        // reset state
        chk("rst_rotate", {31'd0, d1_rotate}, 32'd0);
        chk("rst_txv",    {31'd0, d1_tx_valid}, 32'd0);
        chk("rst_txd",    {24'd0, d1_tx_data}, 32'h00);
        chk("rst_indata", {24'd0, d1_inputData}, 32'h00);
        chk("rst_char",   {16'd0, d1_char_count}, 32'd0);
        chk("rst_drop",   {16'd0, d1_drop_count}, 32'd0);
        chk("rst_busy",   {31'd0, d1_busy}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rel_ready", {31'd0, d1_rx_ready}, 32'd1);

        // 'A' -> engine returns 'B'
        i_rx_data = 8'h41; i_outputData = 8'h42; i_valid = 1'b1; i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        chk("a_rot_c1",  {31'd0, d1_rotate}, 32'd1);
        chk("a_busy",    {31'd0, d1_busy}, 32'd1);
        chk("a_indata",  {24'd0, d1_inputData}, 32'h41);
        chk("a_noready", {31'd0, d1_rx_ready}, 32'd0);
        tick();
        chk("a_rot_c2",  {31'd0, d1_rotate}, 32'd0);
        repeat (3) tick();
        chk("a_txv_e4",  {31'd0, d1_tx_valid}, 32'd0);
        tick();
        chk("a_txv_e5",  {31'd0, d1_tx_valid}, 32'd1);
        chk("a_txd_e5",  {24'd0, d1_tx_data}, 32'h42);
        chk("a_char",    {16'd0, d1_char_count}, 32'd1);
        chk("a_idle",    {31'd0, d1_busy}, 32'd0);
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        chk("a_popped",  {31'd0, d1_tx_valid}, 32'd0);

        // space: forwarded by pass instance, dropped by the other
        i_rx_data = 8'h20; i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        chk("sp_txv",    {31'd0, d1_tx_valid}, 32'd1);
        chk("sp_txd",    {24'd0, d1_tx_data}, 32'h20);
        chk("sp_rot",    {31'd0, d1_rotate}, 32'd0);
        chk("sp_busy",   {31'd0, d1_busy}, 32'd0);
        chk("sp0_txv",   {31'd0, d0_tx_valid}, 32'd0);
        chk("sp0_drop",  {16'd0, d0_drop_count}, 32'd1);
        tick();
        chk("sp_rot2",   {31'd0, d1_rotate}, 32'd0);
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;

        // engine reports invalid at capture
        i_rx_data = 8'h63; i_outputData = 8'h70; i_valid = 1'b0; i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        repeat (5) tick();
        chk("inv_txv",   {31'd0, d1_tx_valid}, 32'd0);
        chk("inv_drop",  {16'd0, d1_drop_count}, 32'd1);
        chk("inv_char",  {16'd0, d1_char_count}, 32'd1);
        chk("inv_idle",  {31'd0, d1_busy}, 32'd0);
        chk("inv_indat", {24'd0, d1_inputData}, 32'h63);

        // settings reload during WAIT aborts
        i_rx_data = 8'h44; i_outputData = 8'h45; i_valid = 1'b1; i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        tick();
        i_update_settings = 1'b1;
        #1;
        chk("upd_busy",  {31'd0, d1_busy}, 32'd1);
        tick();
        chk("upd_idle",  {31'd0, d1_busy}, 32'd0);
        chk("upd_drop",  {16'd0, d1_drop_count}, 32'd2);
        chk("upd_nordy", {31'd0, d1_rx_ready}, 32'd0);
        chk("upd_txv",   {31'd0, d1_tx_valid}, 32'd0);
        i_update_settings = 1'b0;
        #1;
        chk("upd_rdy",   {31'd0, d1_rx_ready}, 32'd1);

        // fill FIFO with tx blocked, then drain in order
        send_letter(8'h41, 8'h61, 1'b1);
        send_letter(8'h42, 8'h62, 1'b1);
        send_letter(8'h43, 8'h63, 1'b1);
        send_letter(8'h44, 8'h64, 1'b1);
        chk("full_nordy", {31'd0, d1_rx_ready}, 32'd0);
        chk("full_head",  {24'd0, d1_tx_data}, 32'h61);
        i_rx_data = 8'h45; i_outputData = 8'h65; i_valid = 1'b1; i_rx_valid = 1'b1;
        tick();
        chk("full_hold",  {31'd0, d1_busy}, 32'd0);
        chk("full_stab",  {24'd0, d1_tx_data}, 32'h61);
        i_tx_ready = 1'b1;
        tick();
        chk("drn_1",      {24'd0, d1_tx_data}, 32'h62);
        chk("drn_rdy",    {31'd0, d1_rx_ready}, 32'd1);
        tick();
        i_rx_valid = 1'b0;
        chk("drn_acc5",   {31'd0, d1_busy}, 32'd1);
        chk("drn_2",      {24'd0, d1_tx_data}, 32'h63);
        tick();
        chk("drn_3",      {24'd0, d1_tx_data}, 32'h64);
        tick();
        chk("drn_empty",  {31'd0, d1_tx_valid}, 32'd0);
        repeat (3) tick();
        chk("fifth_txv",  {31'd0, d1_tx_valid}, 32'd1);
        chk("fifth_txd",  {24'd0, d1_tx_data}, 32'h65);
        chk("fifth_char", {16'd0, d1_char_count}, 32'd6);
        tick();
        i_tx_ready = 1'b0;
        chk("fifth_pop",  {31'd0, d1_tx_valid}, 32'd0);

        // reset while in WAIT with two bytes queued
        i_rx_data = 8'h31; i_rx_valid = 1'b1;
        tick();
        i_rx_data = 8'h32;
        tick();
        i_rx_data = 8'h46;
        tick();
        i_rx_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy",  {31'd0, d1_busy}, 32'd1);
        chk("mid_txv",   {31'd0, d1_tx_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_rotate", {31'd0, d1_rotate}, 32'd0);
        chk("ar_txv",    {31'd0, d1_tx_valid}, 32'd0);
        chk("ar_txd",    {24'd0, d1_tx_data}, 32'h00);
        chk("ar_char",   {16'd0, d1_char_count}, 32'd0);
        chk("ar_drop",   {16'd0, d1_drop_count}, 32'd0);
        chk("ar_busy",   {31'd0, d1_busy}, 32'd0);
        chk("ar_indata", {24'd0, d1_inputData}, 32'h00);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_rdy",    {31'd0, d1_rx_ready}, 32'd1);
        tick();
        chk("ar_rdy2",   {31'd0, d1_rx_ready}, 32'd1);
        chk("ar_txv2",   {31'd0, d1_tx_valid}, 32'd0);
        chk("ar_drop2",  {16'd0, d1_drop_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
